// File: rtl/alg_frm_done_gen.sv
// alg_frm_done_gen
//   Passive frame-completion monitor. It watches NUM_PROC valid/ready/last
//   streams and counts beats and frames on each one. For every stream it holds
//   one completed-frame event. Completions that happen in the same cycle are
//   serialised by a round-robin arbiter onto a single registered frm_done
//   interface.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   en            count enable; while low, no beat is recorded
//   mon_valid     per-stream valid (sampled only)
//   mon_ready     per-stream ready (sampled only)
//   mon_last      per-stream end-of-frame marker, qualified by valid&ready
//   frm_done      one-cycle frame-complete pulse
//   frm_proc      stream index of the event
//   frm_idx       0-based frame number of that stream
//   frm_beats     beats in the frame, including the last beat
//   beat_err      frm_beats differs from FRM_BEATS (only when FRM_BEATS != 0)
//   ovf           sticky: a completion was dropped while its event was pending
//   frame_total   number of frm_done pulses emitted since reset
module alg_frm_done_gen #(
  parameter int NUM_PROC  = 4,
  parameter int CNT_W     = 32,
  parameter int FRM_BEATS = 0,
  parameter int PROC_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_PROC-1:0] mon_valid,
  input  logic [NUM_PROC-1:0] mon_ready,
  input  logic [NUM_PROC-1:0] mon_last,
  output logic                frm_done,
  output logic [PROC_W-1:0]   frm_proc,
  output logic [CNT_W-1:0]    frm_idx,
  output logic [CNT_W-1:0]    frm_beats,
  output logic                beat_err,
  output logic                ovf,
  output logic [CNT_W-1:0]    frame_total
);

  localparam logic [CNT_W-1:0] FRM_BEATS_C = CNT_W'(FRM_BEATS);
  localparam bit               CHK_EN      = (FRM_BEATS != 0);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  logic [NUM_PROC-1:0] pend_vec;
  logic [NUM_PROC-1:0] drop_vec;
  logic [CNT_W-1:0]    pend_idx_arr   [NUM_PROC];
  logic [CNT_W-1:0]    pend_beats_arr [NUM_PROC];

  logic                gnt_vld;
  logic [PROC_W-1:0]   gnt_idx;
  logic [PROC_W-1:0]   cand;

  logic                frm_done_q;
  logic [PROC_W-1:0]   frm_proc_q;
  logic [CNT_W-1:0]    frm_idx_q;
  logic [CNT_W-1:0]    frm_beats_q;
  logic                beat_err_q;
  logic                ovf_q;
  logic [CNT_W-1:0]    frame_total_q;
  logic [PROC_W-1:0]   ptr_q;

  // Round-robin search. It starts one past the last grant and wraps around.
  // The final candidate is the last winner itself.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= unsigned'(NUM_PROC); k++) begin
      int unsigned c;
      c = 32'(ptr_q) + k;
      if (c >= unsigned'(NUM_PROC)) begin
        c = c - unsigned'(NUM_PROC);
      end
      cand = PROC_W'(c);
      if (!gnt_vld && pend_vec[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  for (genvar g = 0; g < NUM_PROC; g++) begin : g_stream
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
    logic [CNT_W-1:0] pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0] pend_beats_q, pend_beats_d;
    logic             pend_q, pend_d;
    logic             hit;
    logic             granted;
    logic             drop;

    assign hit     = en & mon_valid[g] & mon_ready[g];
    assign granted = gnt_vld && (gnt_idx == PROC_W'(g));

    // If a completion arrives in the cycle this stream's event is granted,
    // the new event replaces the old one. It is dropped only when the old
    // event is still waiting.
    always_comb begin
      beat_cnt_d   = beat_cnt_q;
      frm_cnt_d    = frm_cnt_q;
      pend_idx_d   = pend_idx_q;
      pend_beats_d = pend_beats_q;
      pend_d       = pend_q & ~granted;
      drop         = 1'b0;
      if (hit) begin
        if (mon_last[g]) begin
          frm_cnt_d  = frm_cnt_q + ONE;
          beat_cnt_d = '0;
          if (!pend_q || granted) begin
            pend_d       = 1'b1;
            pend_idx_d   = frm_cnt_q;
            pend_beats_d = beat_cnt_q + ONE;
          end else begin
            drop = 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + ONE;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        beat_cnt_q   <= '0;
        frm_cnt_q    <= '0;
        pend_idx_q   <= '0;
        pend_beats_q <= '0;
        pend_q       <= 1'b0;
      end else begin
        beat_cnt_q   <= beat_cnt_d;
        frm_cnt_q    <= frm_cnt_d;
        pend_idx_q   <= pend_idx_d;
        pend_beats_q <= pend_beats_d;
        pend_q       <= pend_d;
      end
    end

    assign pend_vec[g]       = pend_q;
    assign drop_vec[g]       = drop;
    assign pend_idx_arr[g]   = pend_idx_q;
    assign pend_beats_arr[g] = pend_beats_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_done_q    <= 1'b0;
      frm_proc_q    <= '0;
      frm_idx_q     <= '0;
      frm_beats_q   <= '0;
      beat_err_q    <= 1'b0;
      ovf_q         <= 1'b0;
      frame_total_q <= '0;
      ptr_q         <= PROC_W'(NUM_PROC - 1);
    end else begin
      frm_done_q <= gnt_vld;
      beat_err_q <= gnt_vld && CHK_EN && (pend_beats_arr[gnt_idx] != FRM_BEATS_C);
      ovf_q      <= ovf_q | (|drop_vec);
      if (gnt_vld) begin
        frm_proc_q    <= gnt_idx;
        frm_idx_q     <= pend_idx_arr[gnt_idx];
        frm_beats_q   <= pend_beats_arr[gnt_idx];
        ptr_q         <= gnt_idx;
        frame_total_q <= frame_total_q + ONE;
      end
    end
  end

  assign frm_done    = frm_done_q;
  assign frm_proc    = frm_proc_q;
  assign frm_idx     = frm_idx_q;
  assign frm_beats   = frm_beats_q;
  assign beat_err    = beat_err_q;
  assign ovf         = ovf_q;
  assign frame_total = frame_total_q;

endmodule

// File: tb/tb_alg_frm_done_gen.sv
module tb_alg_frm_done_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  mon_valid;
  logic [3:0]  mon_ready;
  logic [3:0]  mon_last;

  logic        done,  done8;
  logic [1:0]  proc,  proc8;
  logic [31:0] idx,   idx8;
  logic [31:0] beats, beats8;
  logic        berr,  berr8;
  logic        ovf,   ovf8;
  logic [31:0] total, total8;

  int checks = 0;
  int passes = 0;

  alg_frm_done_gen #(.NUM_PROC(4), .CNT_W(32), .FRM_BEATS(0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .frm_done(done), .frm_proc(proc), .frm_idx(idx), .frm_beats(beats),
    .beat_err(berr), .ovf(ovf), .frame_total(total)
  );

  alg_frm_done_gen #(.NUM_PROC(4), .CNT_W(32), .FRM_BEATS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .frm_done(done8), .frm_proc(proc8), .frm_idx(idx8), .frm_beats(beats8),
    .beat_err(berr8), .ovf(ovf8), .frame_total(total8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] r, input logic [3:0] l);
    mon_valid = v;
    mon_ready = r;
    mon_last  = l;
    tick();
  endtask

  task automatic idle();
    drive(4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0;
    mon_valid = '0; mon_ready = '0; mon_last = '0;
    #2 rst = 1'b1;
    tick(); tick();
    chk("rst_done", done, 0);
    chk("rst_proc", proc, 0);
    chk("rst_idx", idx, 0);
    chk("rst_beats", beats, 0);
    chk("rst_total", total, 0);
    chk("rst_ovf", ovf, 0);
    #2 rst = 1'b0;
    tick();
    en = 1'b1;

    // Stream 0: frames of 4, 1 and 7 beats
    repeat (3) drive(4'h1, 4'hF, 4'h0);
    drive(4'h1, 4'hF, 4'h1);
    chk("f0_lat_n1", done, 0);
    idle();
    chk("f0_done", done, 1);
    chk("f0_proc", proc, 0);
    chk("f0_idx", idx, 0);
    chk("f0_beats", beats, 4);
    chk("f0_berr", berr, 0);
    chk("f0_berr8", berr8, 1);
    chk("f0_total", total, 1);
    idle();
    chk("f0_pulse", done, 0);
    drive(4'h1, 4'hF, 4'h1);
    chk("f1_lat_n1", done, 0);
    idle();
    chk("f1_done", done, 1);
    chk("f1_idx", idx, 1);
    chk("f1_beats", beats, 1);
    idle();
    repeat (6) drive(4'h1, 4'hF, 4'h0);
    drive(4'h1, 4'hF, 4'h1);
    chk("f2_lat_n1", done, 0);
    idle();
    chk("f2_done", done, 1);
    chk("f2_idx", idx, 2);
    chk("f2_beats", beats, 7);
    chk("f2_total", total, 3);
    chk("f2_ovf", ovf, 0);
    idle();
    chk("f2_pulse", done, 0);

    // All four streams complete together; the last grant went to stream 0
    drive(4'hF, 4'hF, 4'hF);
    chk("rr_n1", done, 0);
    idle();
    chk("rr_a_done", done, 1); chk("rr_a_proc", proc, 1); chk("rr_a_idx", idx, 0);
    idle();
    chk("rr_b_done", done, 1); chk("rr_b_proc", proc, 2); chk("rr_b_idx", idx, 0);
    idle();
    chk("rr_c_done", done, 1); chk("rr_c_proc", proc, 3); chk("rr_c_idx", idx, 0);
    idle();
    chk("rr_d_done", done, 1); chk("rr_d_proc", proc, 0); chk("rr_d_idx", idx, 3);
    chk("rr_d_beats", beats, 1);
    idle();
    chk("rr_end", done, 0);
    chk("rr_total", total, 7);

    // Stream 2: frame of 8 beats, then a frame of 7 beats, against FRM_BEATS=8
    repeat (7) drive(4'h4, 4'hF, 4'h0);
    drive(4'h4, 4'hF, 4'h4);
    idle();
    chk("b8_done", done8, 1);
    chk("b8_proc", proc8, 2);
    chk("b8_beats", beats8, 8);
    chk("b8_berr", berr8, 0);
    repeat (6) drive(4'h4, 4'hF, 4'h0);
    drive(4'h4, 4'hF, 4'h4);
    idle();
    chk("b7_done", done8, 1);
    chk("b7_beats", beats8, 7);
    chk("b7_berr8", berr8, 1);
    chk("b7_berr0", berr, 0);
    idle();
    chk("b7_berr_pulse", berr8, 0);

    // Overflow: streams 0, 2 and 3 are pending while stream 1 completes twice
    drive(4'hD, 4'hF, 4'hD);
    drive(4'h2, 4'hF, 4'h2);
    chk("ov_a_proc", proc, 3); chk("ov_a_idx", idx, 1); chk("ov_a_ovf", ovf, 0);
    drive(4'h2, 4'hF, 4'h2);
    chk("ov_b_proc", proc, 0); chk("ov_b_idx", idx, 4); chk("ov_b_ovf", ovf, 1);
    idle();
    chk("ov_c_done", done, 1); chk("ov_c_proc", proc, 1); chk("ov_c_idx", idx, 1);
    idle();
    chk("ov_d_proc", proc, 2); chk("ov_d_idx", idx, 3);
    idle();
    chk("ov_e_done", done, 0);
    drive(4'h2, 4'hF, 4'h2);
    idle();
    chk("ov_f_done", done, 1); chk("ov_f_proc", proc, 1); chk("ov_f_idx", idx, 3);
    chk("ov_sticky", ovf, 1);
    chk("ov_total", total, 14);

    // en low in the middle of a stream 3 frame; ignored-last cases
    repeat (5) drive(4'h8, 4'hF, 4'h0);
    en = 1'b0;
    repeat (2) drive(4'h8, 4'hF, 4'h0);
    drive(4'h8, 4'hF, 4'h8);
    idle();
    chk("en_low_done", done, 0);
    en = 1'b1;
    drive(4'h8, 4'h0, 4'h8);
    drive(4'h0, 4'hF, 4'h8);
    idle();
    chk("last_ign_done", done, 0);
    drive(4'h8, 4'hF, 4'h0);
    drive(4'h8, 4'hF, 4'h8);
    idle();
    chk("en_done", done, 1);
    chk("en_proc", proc, 3);
    chk("en_idx", idx, 2);
    chk("en_beats", beats, 7);

    // Asynchronous reset with stream 0 mid-frame and stream 1 pending
    idle();
    repeat (2) drive(4'h1, 4'hF, 4'h0);
    drive(4'h3, 4'hF, 4'h2);
    mon_valid = '0; mon_ready = '0; mon_last = '0;
    #2 rst = 1'b1;
    #1;
    chk("ar_done", done, 0);
    chk("ar_proc", proc, 0);
    chk("ar_idx", idx, 0);
    chk("ar_beats", beats, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_total", total, 0);
    tick(); tick();
    #2 rst = 1'b0;
    tick();
    chk("ar_post_a", done, 0);
    tick();
    chk("ar_post_b", done, 0);
    drive(4'h1, 4'hF, 4'h0);
    drive(4'h1, 4'hF, 4'h1);
    idle();
    chk("ar_f_done", done, 1);
    chk("ar_f_proc", proc, 0);
    chk("ar_f_idx", idx, 0);
    chk("ar_f_beats", beats, 2);
    chk("ar_f_total", total, 1);
    chk("ar_f_ovf", ovf, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
